motion_sequencer: RTL

Run-level controller for the drive PWM path. On a `go` request it sequences the accelerator ramp, a timed constant-duty cruise phase, and the decelerator ramp. It muxes the active phase's PWM onto the single motor PWM output and lets an `abort` input cut cruise or acceleration short into deceleration. It sits between the top-level command logic and the accelerator/decelerator blocks, all on the 1 MHz clock.

---
 rtl/motion_sequencer_if.sv | 28 ++
 rtl/motion_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/motion_sequencer_if.sv
// motion_sequencer_if: handshake bundle between the run sequencer and the
// accelerator/decelerator ramp blocks (start pulses out, done/PWM back).
interface motion_sequencer_if;
   logic accel_start;
   logic accel_done;
   logic accel_pwm;
   logic decel_start;
   logic decel_done;
   logic decel_pwm;

   modport master (
      output accel_start,
      output decel_start,
      input  accel_done,
      input  accel_pwm,
      input  decel_done,
      input  decel_pwm
   );

   modport slave (
      input  accel_start,
      input  decel_start,
      output accel_done,
      output accel_pwm,
      output decel_done,
      output decel_pwm
   );
endinterface

// File: rtl/motion_sequencer.sv
// motion_sequencer: run-level controller for the drive PWM path.
// Sequences ACCEL -> timed constant-duty CRUISE -> DECEL on a go edge and
// muxes the active phase's PWM onto a single registered motor output.
// Optional ACCEL/DECEL watchdog compiled in with `define MOTION_WATCHDOG_EN.
module motion_sequencer #(
   parameter int unsigned PERIOD_US = 100,
   parameter int unsigned US_PER_MS = 1000,
   parameter int unsigned WDT_MS    = 2000
) (
   input  logic               clk_1mhz,
   input  logic               reset_n,
   input  logic               go,
   input  logic               abort,
   input  logic [15:0]        cruise_ms,
   input  logic [6:0]         cruise_duty,
   motion_sequencer_if.master drv,
   output logic               pwm_out,
   output logic               busy,
   output logic               run_done,
   output logic               fault,
   output logic [2:0]         state
);

   localparam int unsigned US_W  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
   localparam int unsigned CYC_W = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCEL  = 3'd1,
      S_CRUISE = 3'd2,
      S_DECEL  = 3'd3,
      S_DONE   = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic               go_prev_q, adone_prev_q, ddone_prev_q;
   logic               accel_start_q, decel_start_q;
   logic               pwm_q, busy_q, done_q;
   logic [US_W-1:0]    us_q;
   logic [CYC_W-1:0]   cyc_q;
   logic [15:0]        ms_q;
   logic [15:0]        ms_cap_q;
   logic [6:0]         duty_q;

   logic               go_edge, adone_edge, ddone_edge;
   logic               us_wrap, cyc_last, cruise_end, wdt_end;
   logic               count_en, entering, pwm_src;

   // Edge detection, phase timers' terminal conditions, next state and PWM source
   always_comb begin
      go_edge    = go & ~go_prev_q;
      adone_edge = drv.accel_done & ~adone_prev_q;
      ddone_edge = drv.decel_done & ~ddone_prev_q;
      us_wrap    = (us_q == US_W'(PERIOD_US - 1));
      cyc_last   = (cyc_q == CYC_W'(US_PER_MS - 1));
      // ms count including this cycle's increment, so CRUISE lasts exactly
      // cruise_ms*US_PER_MS cycles; a zero request leaves after one cycle
      cruise_end = (ms_cap_q == '0) ||
                   (cyc_last && ((32'(ms_q) + 32'd1) == 32'(ms_cap_q)));
`ifdef MOTION_WATCHDOG_EN
      wdt_end    = cyc_last && ((32'(ms_q) + 32'd1) == WDT_MS);
      count_en   = (state_q == S_CRUISE) || (state_q == S_ACCEL) ||
                   (state_q == S_DECEL);
`else
      wdt_end    = 1'b0;
      count_en   = (state_q == S_CRUISE);
`endif
      state_d    = state_q;
      pwm_src    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (go_edge && !abort) state_d = S_ACCEL;
         end
         S_ACCEL: begin
            pwm_src = drv.accel_pwm;
            if (abort)           state_d = S_DECEL;
            else if (adone_edge) state_d = S_CRUISE;
            else if (wdt_end)    state_d = S_FAULT;
         end
         S_CRUISE: begin
            pwm_src = (32'(us_q) < 32'(duty_q));
            if (abort || cruise_end) state_d = S_DECEL;
         end
         S_DECEL: begin
            pwm_src = drv.decel_pwm;
            if (ddone_edge)   state_d = S_DONE;
            else if (wdt_end) state_d = S_FAULT;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      entering = (state_d != state_q);
   end

   // Sequencer state, registered outputs, edge history and phase counters
   always_ff @(posedge clk_1mhz) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         go_prev_q     <= 1'b0;
         adone_prev_q  <= 1'b0;
         ddone_prev_q  <= 1'b0;
         accel_start_q <= 1'b0;
         decel_start_q <= 1'b0;
         pwm_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         us_q          <= '0;
         cyc_q         <= '0;
         ms_q          <= '0;
         ms_cap_q      <= '0;
         duty_q        <= '0;
      end else begin
         go_prev_q     <= go;
         adone_prev_q  <= drv.accel_done;
         ddone_prev_q  <= drv.decel_done;
         state_q       <= state_d;
         accel_start_q <= entering && (state_d == S_ACCEL);
         decel_start_q <= entering && (state_d == S_DECEL);
         pwm_q         <= (state_d == S_FAULT) ? 1'b0 : pwm_src;
         busy_q        <= (state_d == S_ACCEL) || (state_d == S_CRUISE) ||
                          (state_d == S_DECEL);
         done_q        <= (state_d == S_DONE);
         if (entering) begin
            us_q  <= '0;
            cyc_q <= '0;
            ms_q  <= '0;
         end else if (count_en) begin
            us_q <= us_wrap ? '0 : us_q + US_W'(1);
            if (cyc_last) begin
               cyc_q <= '0;
               ms_q  <= ms_q + 16'd1;
            end else begin
               cyc_q <= cyc_q + CYC_W'(1);
            end
         end
         if (entering && (state_d == S_CRUISE)) begin
            ms_cap_q <= cruise_ms;
            duty_q   <= (cruise_duty > 7'd100) ? 7'd100 : cruise_duty;
         end
      end
   end

`ifdef MOTION_WATCHDOG_EN
   logic fault_q;

   // Fault flag follows the FAULT state, cleared only by reset
   always_ff @(posedge clk_1mhz) begin
      if (!reset_n) fault_q <= 1'b0;
      else          fault_q <= (state_d == S_FAULT);
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign drv.accel_start = accel_start_q;
   assign drv.decel_start = decel_start_q;
   assign pwm_out         = pwm_q;
   assign busy            = busy_q;
   assign run_done        = done_q;
   assign state           = state_q;

endmodule
